// File: rtl/iot_sensor_pkg.sv
// Shared types and constants for the IoT sensor packet framer path.
package iot_sensor_pkg;

  localparam logic [7:0]  PKT_SYNC_DEFAULT = 8'hAA;
  localparam int unsigned PKT_NUM_BYTES    = 9;
  localparam logic [3:0]  PKT_CHKSUM_IDX   = 4'd8;

  typedef enum logic {PB_IDLE, PB_EMIT} pkt_build_state_e;

  // True for byte indices that exist in a packet (0..PKT_NUM_BYTES-1).
  function automatic logic pkt_idx_valid(input logic [3:0] idx);
    return 32'(idx) < PKT_NUM_BYTES;
  endfunction

  // True for the bytes folded into the checksum (header through timestamp).
  function automatic logic pkt_idx_in_chksum(input logic [3:0] idx);
    return (idx != 4'd0) && (idx < PKT_CHKSUM_IDX);
  endfunction

endpackage

// File: rtl/sensor_packet_builder.sv
// Frames one sensor sample into a 9-byte packet (sync, header, data, timestamp, XOR checksum)
// and streams it out one byte per valid/ready handshake.
module sensor_packet_builder
  import iot_sensor_pkg::*;
#(
  parameter logic [7:0] PKT_SYNC = PKT_SYNC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  input  logic [3:0]  sensor_type_i,
  input  logic [15:0] sensor_data_i,
  input  logic [31:0] timestamp_i,
  output logic [7:0]  byte_out_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        byte_last_o,
  output logic [15:0] packets_sent_o,
  output logic        busy_o
);

  pkt_build_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [3:0]  seq_q, seq_d;
  logic [15:0] pkts_q, pkts_d;
  logic [3:0]  type_q, type_d;
  logic [15:0] data_q, data_d;
  logic [31:0] ts_q, ts_d;
  logic [7:0]  emit_byte;
  logic        xfer;

  always_comb begin
    emit_byte = 8'h00;
    case (idx_q)
      4'd0:    emit_byte = PKT_SYNC;
      4'd1:    emit_byte = {type_q, seq_q};
      4'd2:    emit_byte = data_q[15:8];
      4'd3:    emit_byte = data_q[7:0];
      4'd4:    emit_byte = ts_q[31:24];
      4'd5:    emit_byte = ts_q[23:16];
      4'd6:    emit_byte = ts_q[15:8];
      4'd7:    emit_byte = ts_q[7:0];
      4'd8:    emit_byte = chk_q;
      default: emit_byte = 8'h00;
    endcase
  end

  assign busy_o         = (state_q == PB_EMIT);
  assign byte_valid_o   = busy_o;
  assign byte_out_o     = busy_o ? emit_byte : 8'h00;
  assign byte_last_o    = byte_valid_o && (idx_q == PKT_CHKSUM_IDX);
  assign packets_sent_o = pkts_q;
  assign xfer           = byte_valid_o && byte_ready_i;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    chk_d          = chk_q;
    seq_d          = seq_q;
    pkts_d         = pkts_q;
    type_d         = type_q;
    data_d         = data_q;
    ts_d           = ts_q;
    sample_ready_o = 1'b0;

    case (state_q)
      PB_IDLE: begin
        sample_ready_o = enable_i;
        if (sample_valid_i && enable_i) begin
          type_d  = sensor_type_i;
          data_d  = sensor_data_i;
          ts_d    = timestamp_i;
          idx_d   = 4'd0;
          chk_d   = 8'h00;
          state_d = PB_EMIT;
        end
      end
      PB_EMIT: begin
        // enable_i is deliberately ignored here so a started packet is never truncated.
        if (!pkt_idx_valid(idx_q)) begin
          state_d = PB_IDLE;
          idx_d   = 4'd0;
        end else if (xfer) begin
          if (pkt_idx_in_chksum(idx_q)) begin
            chk_d = chk_q ^ emit_byte;
          end
          if (idx_q == PKT_CHKSUM_IDX) begin
            seq_d   = seq_q + 4'd1;
            pkts_d  = pkts_q + 16'd1;
            idx_d   = 4'd0;
            state_d = PB_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = PB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PB_IDLE;
      idx_q   <= 4'd0;
      chk_q   <= 8'h00;
      seq_q   <= 4'd0;
      pkts_q  <= 16'd0;
      type_q  <= 4'd0;
      data_q  <= 16'd0;
      ts_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      seq_q   <= seq_d;
      pkts_q  <= pkts_d;
      type_q  <= type_d;
      data_q  <= data_d;
      ts_q    <= ts_d;
    end
  end

endmodule

// File: tb/tb_sensor_packet_builder.sv
// Self-checking bench for sensor_packet_builder: vector table plus hand-written corner sequences.
module tb_sensor_packet_builder;
  import iot_sensor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [3:0]  sensor_type = 4'd0;
  logic [15:0] sensor_data = 16'd0;
  logic [31:0] timestamp = 32'd0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        byte_last;
  logic [15:0] packets_sent;
  logic        busy;

  sensor_packet_builder #(.PKT_SYNC(8'hAA)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .sample_valid_i (sample_valid),
    .sample_ready_o (sample_ready),
    .sensor_type_i  (sensor_type),
    .sensor_data_i  (sensor_data),
    .timestamp_i    (timestamp),
    .byte_out_o     (byte_out),
    .byte_valid_o   (byte_valid),
    .byte_ready_i   (byte_ready),
    .byte_last_o    (byte_last),
    .packets_sent_o (packets_sent),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  int          pos = 0;
  int          ready_mode = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  logic [7:0]  last_rx = 8'h00;
  logic [3:0]  exp_seq = 4'd0;
  logic [15:0] exp_pkts = 16'd0;

  typedef struct {
    logic [3:0]  t;
    logic [15:0] d;
    logic [31:0] ts;
    int          mode;
    logic [7:0]  exp_chk;
    bit          chk_known;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_byte(input int i, input logic [3:0] t, input logic [3:0] s,
                                            input logic [15:0] d, input logic [31:0] ts);
    case (i)
      0:       return 8'hAA;
      1:       return {t, s};
      2:       return d[15:8];
      3:       return d[7:0];
      4:       return ts[31:24];
      5:       return ts[23:16];
      6:       return ts[15:8];
      7:       return ts[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_packet(input logic [3:0] t, input logic [15:0] d, input logic [31:0] ts);
    logic [7:0] chk;
    logic [7:0] b;
    chk = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = model_byte(i, t, exp_seq, d, ts);
      if (i >= 1) chk = chk ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(chk);
    exp_seq  = exp_seq + 4'd1;
    exp_pkts = exp_pkts + 16'd1;
  endtask

  // Output monitor: drives byte_ready, predicts transfers, and checks against the scoreboard.
  always begin
    logic [7:0] e;
    @(negedge clk);
    if (rst) begin
      pos        = 0;
      prev_stall = 1'b0;
      byte_ready = 1'b1;
    end else begin
      byte_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (prev_stall) begin
        check("stall_valid", 32'(byte_valid), 32'd1);
        check("stall_hold", 32'(byte_out), 32'(prev_byte));
      end
      if (byte_valid) begin
        check("byte_last", 32'(byte_last), 32'(pos == 8));
        if (byte_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_byte", 32'(byte_out), 32'h100);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(byte_out), 32'(e));
          end
          last_rx = byte_out;
          pos     = (pos == 8) ? 0 : pos + 1;
        end
      end else begin
        check("last_idle", 32'(byte_last), 32'd0);
      end
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
    end
  end

  task automatic send(input logic [3:0] t, input logic [15:0] d, input logic [31:0] ts);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    sensor_type  = t;
    sensor_data  = d;
    timestamp    = ts;
    sample_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (sample_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      push_packet(t, d, ts);
      #1;
      sample_valid = 1'b0;
      check("latency_valid", 32'(byte_valid), 32'd1);
      check("latency_sync", 32'(byte_out), 32'hAA);
    end else begin
      sample_valid = 1'b0;
      check("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    check("drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  task automatic wait_pos(input int p);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      if (pos == p && byte_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_pos", 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_seq  = 4'd0;
    exp_pkts = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{t: 4'h3, d: 16'h1234, ts: 32'hDEADBEEF, mode: 0, exp_chk: 8'h34, chk_known: 1};
    vecs[1] = '{t: 4'h0, d: 16'h0000, ts: 32'h00000000, mode: 0, exp_chk: 8'h01, chk_known: 1};
    vecs[2] = '{t: 4'hA, d: 16'hBEEF, ts: 32'h12345678, mode: 1, exp_chk: 8'h00, chk_known: 0};
    vecs[3] = '{t: 4'hF, d: 16'hFFFF, ts: 32'hFFFFFFFF, mode: 1, exp_chk: 8'hF3, chk_known: 1};
    vecs[4] = '{t: 4'h5, d: 16'h00FF, ts: 32'h0F0F0F0F, mode: 1, exp_chk: 8'h00, chk_known: 0};

    // Reset state
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_last", 32'(byte_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte", 32'(byte_out), 32'd0);
    check("rst_pkts", 32'(packets_sent), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(sample_ready), 32'd1);

    // Vector table: basic packet, checksum cases, backpressure
    for (int i = 0; i < 5; i++) begin
      ready_mode = vecs[i].mode;
      send(vecs[i].t, vecs[i].d, vecs[i].ts);
      wait_done();
      if (vecs[i].chk_known) check("checksum", 32'(last_rx), 32'(vecs[i].exp_chk));
      check("pkts_sent", 32'(packets_sent), 32'(exp_pkts));
    end

    // Enable dropped mid-packet: packet completes
    ready_mode = 0;
    send(4'h7, 16'hCAFE, 32'h01020304);
    wait_pos(4);
    enable = 1'b0;
    wait_done();
    check("enable_pkts", 32'(packets_sent), 32'(exp_pkts));
    @(negedge clk);
    sample_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check("dis_ready", 32'(sample_ready), 32'd0);
      check("dis_valid", 32'(byte_valid), 32'd0);
    end
    sample_valid = 1'b0;
    enable = 1'b1;

    // Reset mid-packet
    send(4'h9, 16'h5A5A, 32'hA5A5A5A5);
    wait_pos(5);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(byte_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pkts", 32'(packets_sent), 32'd0);
    exp_q.delete();
    exp_seq  = 4'd0;
    exp_pkts = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 1;
    send(4'h2, 16'h8001, 32'h7FFF0001);
    wait_done();
    check("post_rst_pkts", 32'(packets_sent), 32'd1);

    // Sequence wrap over 17 packets
    pulse_reset();
    ready_mode = 0;
    for (int i = 0; i < 17; i++) begin
      send(4'(i), 16'($urandom), $urandom);
      wait_done();
    end
    check("wrap_pkts", 32'(packets_sent), 32'd17);
    check("wrap_last_hdr_seq", 32'(exp_seq), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
